// File: rtl/sram_bridge.sv
// sram_bridge: bridges a 32-bit request/response load/store port to a 16-bit
// asynchronous SRAM. Each word is done as two half-word SRAM cycles (LO then HI);
// halves whose byte enables are all zero are skipped on writes.
// Optional feature macro: SRAM_BRIDGE_ALIGN_CHECK_EN adds rsp_err and answers
// misaligned requests immediately without touching the SRAM.
// WAIT_CYCLES must be >= 1.
module sram_bridge #(
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_be,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
`ifdef SRAM_BRIDGE_ALIGN_CHECK_EN
  output logic              rsp_err,
`endif
  output logic [ADDR_W-1:0] sram_adr,
  inout  wire  [15:0]       sram_dq,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n
);

  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES);      // recovery cycle
  localparam logic [CW-1:0] CNT_SMPL = CW'(WAIT_CYCLES - 1);  // last strobe cycle

  typedef enum logic [1:0] {IDLE, ACC_LO, ACC_HI, RESP} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-2:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          be_q, be_d;
  logic                err_q, err_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                ready_q, ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic                ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic                ub_n_q, ub_n_d, lb_n_q, lb_n_d;
  logic                dq_oe_q, dq_oe_d;
  logic [15:0]         dq_out_q, dq_out_d;
  logic                misalign;
  logic                acc_d, strb_d;
  logic [1:0]          half_be_d;
  logic                unused_addr;

`ifdef SRAM_BRIDGE_ALIGN_CHECK_EN
  assign misalign = |req_addr[1:0];
  assign rsp_err  = err_q & rsp_valid_q;
`else
  assign misalign = 1'b0;
`endif
  // Upper address bits beyond the SRAM and the byte offset are deliberately dropped.
  assign unused_addr = ^{req_addr[31:ADDR_W+1], req_addr[1:0]};

  // Next-state, capture and registered-output values; outputs are derived from the
  // next state so every SRAM strobe comes straight out of a flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: if (req_valid && ready_q) begin
        we_d    = req_we;
        addr_d  = req_addr[ADDR_W:2];
        wdata_d = req_wdata;
        be_d    = req_be;
        err_d   = misalign;
        rdata_d = '0;
        cnt_d   = '0;
        if (misalign)                           state_d = RESP;
        else if (req_we && req_be == 4'b0000)   state_d = RESP;
        else if (req_we && req_be[1:0] == 2'b0) state_d = ACC_HI;
        else                                    state_d = ACC_LO;
      end
      ACC_LO, ACC_HI: begin
        if (!we_q && cnt_q == CNT_SMPL) begin
          if (state_q == ACC_LO) rdata_d[15:0]  = sram_dq;
          else                   rdata_d[31:16] = sram_dq;
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = (state_q == ACC_LO && !(we_q && be_q[3:2] == 2'b0)) ? ACC_HI : RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    acc_d       = (state_d == ACC_LO) || (state_d == ACC_HI);
    strb_d      = acc_d && (cnt_d != CNT_LAST);
    half_be_d   = (state_d == ACC_HI) ? be_d[3:2] : be_d[1:0];
    ce_n_d      = !acc_d;
    we_n_d      = !(strb_d && we_d);
    oe_n_d      = !(strb_d && !we_d);
    ub_n_d      = acc_d ? (we_d ? ~half_be_d[1] : 1'b0) : 1'b1;
    lb_n_d      = acc_d ? (we_d ? ~half_be_d[0] : 1'b0) : 1'b1;
    dq_oe_d     = acc_d && we_d;
    dq_out_d    = (state_d == ACC_HI) ? wdata_d[31:16] : wdata_d[15:0];
    adr_d       = acc_d ? {addr_d, (state_d == ACC_HI)} : adr_q;
    ready_d     = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    rsp_rdata_d = (state_d == RESP && !we_d && !err_d) ? rdata_d : 32'h0;
  end

  // State, captured request and registered SRAM/CPU-side outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      adr_q       <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      ub_n_q      <= 1'b1;
      lb_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
      dq_out_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      adr_q       <= adr_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      ub_n_q      <= ub_n_d;
      lb_n_q      <= lb_n_d;
      dq_oe_q     <= dq_oe_d;
      dq_out_q    <= dq_out_d;
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign sram_adr  = adr_q;
  assign sram_ce_n = ce_n_q;
  assign sram_oe_n = oe_n_q;
  assign sram_we_n = we_n_q;
  assign sram_ub_n = ub_n_q;
  assign sram_lb_n = lb_n_q;
  assign sram_dq   = dq_oe_q ? dq_out_q : 16'hzzzz;

endmodule

// File: tb/tb_sram_bridge.sv
// tb_sram_bridge: two bridges (WAIT_CYCLES=1 and 3) each on a small SRAM model;
// expected responses are queued at accept time and matched against logged responses.
module tb_sram_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  int          cyc = 0;
  int          n_vec = 0, n_err = 0;

  typedef struct { logic [31:0] rdata; logic err; int cyc; } rsp_t;
  typedef struct { logic [31:0] rdata; logic err; int lat; int acc; } exp_t;

  exp_t exp_q[$];
  int   rp [2];

  logic [4:0]  strb_a [2];
  logic        rdy_a [2], rspv_a [2], w_ub_a [2], w_lb_a [2];
  logic [19:0] adr_a [2], w_adr_a [2];
  logic [15:0] dq_a [2];
  int          ce_a [2], oe_a [2], we_a [2], wp_a [2], viol_a [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  genvar g;
  generate for (g = 0; g < 2; g++) begin : g_ch
    localparam int WC = (g == 0) ? 1 : 3;
    logic        ready, rsp_valid, ce_n, oe_n, we_n, ub_n, lb_n, err, vld;
    logic [31:0] rdata;
    logic [19:0] adr;
    wire  [15:0] dq;
    logic [15:0] mem [256];
    int          ce_cnt = 0, oe_cnt = 0, we_cnt = 0, wp = 0, viol = 0;
    logic [19:0] w_adr = '0;
    logic        w_ub = 1'b1, w_lb = 1'b1;
    rsp_t        log_q [64];

    assign vld = (g == 0) ? (req_valid && !sel) : (req_valid && sel);

    sram_bridge #(.ADDR_W(20), .WAIT_CYCLES(WC)) u_dut (
      .clk(clk), .reset(rst_n), .req_valid(vld), .req_ready(ready),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rsp_valid), .rsp_rdata(rdata),
`ifdef SRAM_BRIDGE_ALIGN_CHECK_EN
      .rsp_err(err),
`endif
      .sram_adr(adr), .sram_dq(dq), .sram_ce_n(ce_n), .sram_oe_n(oe_n),
      .sram_we_n(we_n), .sram_ub_n(ub_n), .sram_lb_n(lb_n));
`ifndef SRAM_BRIDGE_ALIGN_CHECK_EN
    assign err = 1'b0;
`endif

    // SRAM model: drives read data while selected and output-enabled; a zero
    // keeper holds the bus while deselected so any bridge drive shows up.
    assign dq = ce_n ? 16'h0000 : ((!oe_n && we_n) ? mem[adr[7:0]] : 16'hzzzz);

    // SRAM storage: pattern fill in reset, byte-lane writes while we_n is low.
    always @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < 256; i++) mem[i] <= 16'(i) * 16'h0101;
      end else if (!ce_n && !we_n) begin
        if (!lb_n) mem[adr[7:0]][7:0]  <= dq[7:0];
        if (!ub_n) mem[adr[7:0]][15:8] <= dq[15:8];
      end
    end

    // Strobe activity counters and response log.
    always @(negedge clk) begin
      if (rst_n) begin
        if (!ce_n) ce_cnt <= ce_cnt + 1;
        if (!oe_n) oe_cnt <= oe_cnt + 1;
        if (!we_n) begin
          we_cnt <= we_cnt + 1;
          w_adr  <= adr;
          w_ub   <= ub_n;
          w_lb   <= lb_n;
        end
        if (ce_n && dq != 16'h0000) viol <= viol + 1;
        if (rsp_valid) begin
          log_q[wp % 64] <= '{rdata, err, cyc};
          wp <= wp + 1;
        end
      end
    end

    assign strb_a[g] = {ce_n, oe_n, we_n, ub_n, lb_n};
    assign rdy_a[g]  = ready;
    assign rspv_a[g] = rsp_valid;
    assign adr_a[g]  = adr;
    assign dq_a[g]   = dq;
    assign ce_a[g]   = ce_cnt;
    assign oe_a[g]   = oe_cnt;
    assign we_a[g]   = we_cnt;
    assign wp_a[g]   = wp;
    assign viol_a[g] = viol;
    assign w_adr_a[g] = w_adr;
    assign w_ub_a[g]  = w_ub;
    assign w_lb_a[g]  = w_lb;
  end endgenerate

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, want);
    end
  endtask

  function automatic rsp_t get_log(input int i);
    return sel ? g_ch[1].log_q[i % 64] : g_ch[0].log_q[i % 64];
  endfunction

  // One-cycle request on the selected channel; expectation queued on accept.
  task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input logic [31:0] er, input int lat,
                        input logic ee, input bit push);
    int n = 0;
    @(negedge clk); #1;
    req_we = we; req_addr = a; req_wdata = d; req_be = be; req_valid = 1'b1;
    while (!rdy_a[sel] && n < 40) begin @(negedge clk); #1; n++; end
    chk("accept", {31'b0, rdy_a[sel]}, 32'd1);
    if (push) exp_q.push_back('{er, ee, lat, cyc});
    @(negedge clk); #1;
    req_valid = 1'b0; req_we = ~we; req_addr = $urandom; req_wdata = $urandom;
    req_be = 4'($urandom);
    chk("rdy_drop", {31'b0, rdy_a[sel]}, 32'd0);
  endtask

  // Pop expectations against logged responses, bounded in cycles.
  task automatic drain(input int bound);
    exp_t e;
    rsp_t r;
    int   n = 0;
    while (exp_q.size() > 0 && n < bound) begin
      @(negedge clk); #2; n++;
      while (exp_q.size() > 0 && rp[sel] < wp_a[sel]) begin
        e = exp_q.pop_front();
        r = get_log(rp[sel]);
        rp[sel]++;
        chk("rdata", r.rdata, e.rdata);
        chk("latency", 32'(r.cyc - e.acc), 32'(e.lat));
`ifdef SRAM_BRIDGE_ALIGN_CHECK_EN
        chk("rsp_err", {31'b0, r.err}, {31'b0, e.err});
`endif
      end
    end
    chk("pending", 32'(exp_q.size()), 32'd0);
    chk("extra_rsp", 32'(wp_a[sel] - rp[sel]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ce0, oe0, we0, wp0, n;
    rp[0] = 0; rp[1] = 0;
    rst_n = 1'b0; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; req_be = '0;

    // Reset values, then ready on the first cycle after release.
    repeat (3) @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      chk("rst_strb", {27'b0, strb_a[c]}, 32'h1f);
      chk("rst_ready", {31'b0, rdy_a[c]}, 32'd0);
      chk("rst_rspv", {31'b0, rspv_a[c]}, 32'd0);
      chk("rst_adr", {12'b0, adr_a[c]}, 32'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_ready0", {31'b0, rdy_a[0]}, 32'd1);
    chk("rel_ready1", {31'b0, rdy_a[1]}, 32'd1);

    // Full write then read back, WAIT_CYCLES=1.
    ce0 = ce_a[0]; we0 = we_a[0];
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 5, 1'b0, 1'b1);
    drain(20);
    chk("wr_lo_mem", {16'b0, g_ch[0].mem[8'h08]}, 32'hBEEF);
    chk("wr_hi_mem", {16'b0, g_ch[0].mem[8'h09]}, 32'hDEAD);
    chk("wr_we_cyc", 32'(we_a[0] - we0), 32'd2);
    chk("wr_ce_cyc", 32'(ce_a[0] - ce0), 32'd4);
    chk("wr_last_adr", {12'b0, w_adr_a[0]}, 32'h9);
    oe0 = oe_a[0];
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 5, 1'b0, 1'b1);
    drain(20);
    chk("rd_oe_cyc", 32'(oe_a[0] - oe0), 32'd2);

    // Low-half-only write.
    we0 = we_a[0];
    do_req(1'b1, 32'h20, 32'h12345678, 4'b0011, 32'h0, 3, 1'b0, 1'b1);
    drain(20);
    chk("lo_mem", {16'b0, g_ch[0].mem[8'h10]}, 32'h5678);
    chk("lo_hi_untouched", {16'b0, g_ch[0].mem[8'h11]}, 32'h1111);
    chk("lo_we_cyc", 32'(we_a[0] - we0), 32'd1);
    chk("lo_ublb", {30'b0, w_ub_a[0], w_lb_a[0]}, 32'b00);

    // High-byte-only write, then an all-disabled write.
    we0 = we_a[0];
    do_req(1'b1, 32'h20, 32'hAB000000, 4'b1000, 32'h0, 3, 1'b0, 1'b1);
    drain(20);
    chk("hi_mem", {16'b0, g_ch[0].mem[8'h11]}, 32'hAB11);
    chk("hi_lo_kept", {16'b0, g_ch[0].mem[8'h10]}, 32'h5678);
    chk("hi_adr", {12'b0, w_adr_a[0]}, 32'h11);
    chk("hi_ublb", {30'b0, w_ub_a[0], w_lb_a[0]}, 32'b01);
    chk("hi_we_cyc", 32'(we_a[0] - we0), 32'd1);
    ce0 = ce_a[0];
    do_req(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 32'h0, 1, 1'b0, 1'b1);
    drain(20);
    chk("be0_ce_cyc", 32'(ce_a[0] - ce0), 32'd0);

    // Misaligned read: rejected with the check enabled, aligned down otherwise.
    ce0 = ce_a[0];
`ifdef SRAM_BRIDGE_ALIGN_CHECK_EN
    do_req(1'b0, 32'h13, 32'h0, 4'h0, 32'h0, 1, 1'b1, 1'b1);
    drain(20);
    chk("mis_ce_cyc", 32'(ce_a[0] - ce0), 32'd0);
`else
    do_req(1'b0, 32'h13, 32'h0, 4'h0, 32'hDEADBEEF, 5, 1'b0, 1'b1);
    drain(20);
    chk("mis_ce_cyc", 32'(ce_a[0] - ce0), 32'd4);
`endif

    // WAIT_CYCLES=3 read, then reset during the high half.
    sel = 1'b1;
    ce0 = ce_a[1]; oe0 = oe_a[1];
    do_req(1'b0, 32'h40, 32'h0, 4'h0, 32'h21212020, 9, 1'b0, 1'b1);
    drain(30);
    chk("w3_oe_cyc", 32'(oe_a[1] - oe0), 32'd6);
    chk("w3_ce_cyc", 32'(ce_a[1] - ce0), 32'd8);
    do_req(1'b0, 32'h44, 32'h0, 4'h0, 32'h0, 0, 1'b0, 1'b0);
    n = 0;
    while (!(adr_a[1][0] && !strb_a[1][4]) && n < 30) begin @(negedge clk); n++; end
    chk("w3_hi_seen", {31'b0, adr_a[1][0] & ~strb_a[1][4]}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_strb", {27'b0, strb_a[1]}, 32'h1f);
    chk("abort_dq", {16'b0, dq_a[1]}, 32'h0);
    chk("abort_rspv", {31'b0, rspv_a[1]}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wp0 = wp_a[1];
    repeat (12) @(negedge clk);
    #2;
    chk("abort_no_rsp", 32'(wp_a[1] - wp0), 32'd0);
    chk("abort_ready", {31'b0, rdy_a[1]}, 32'd1);
    chk("bus_keeper0", 32'(viol_a[0]), 32'd0);
    chk("bus_keeper1", 32'(viol_a[1]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram_bridge.md
Name: sram_bridge

Overview:
- Memory-side stage between the pipelined CPU's 32-bit load/store port and the external 16-bit asynchronous SRAM.
- Splits each 32-bit word access into two 16-bit SRAM cycles using a request/response handshake. Drives the SRAM address and the active-low CE/OE/WE/UB/LB strobes, and owns the tri-state data bus.
- Replaces the free-running clock-halving scheme with an FSM in the CPU clock domain.

Parameters:
- ADDR_W, 20: SRAM half-word address width.
- WAIT_CYCLES, 1: strobe-active cycles per half-word access. Must be >= 1; 0 is illegal.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (block held in reset while reset==0).
- req_valid  in  1  CPU access request.
- req_ready  out  1  bridge can accept a request.
- req_we  in  1  1=write, 0=read.
- req_addr  in  32  byte address.
- req_wdata  in  32  write data.
- req_be  in  4  byte enables (bit i = byte i); ignored for reads.
- rsp_valid  out  1  one-cycle pulse: access complete (read data valid / write acknowledged).
- rsp_rdata  out  32  read data; 0 for writes.
- sram_adr  out  ADDR_W  SRAM half-word address.
- sram_dq  inout  16  SRAM data bus.
- sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  out  1 each  active-low SRAM strobes.

Behaviour:
- Reset (async assert) forces the following:
  - state=IDLE; req_ready=0; rsp_valid=0; rsp_rdata=0; sram_adr=0.
  - All sram_*_n outputs =1; sram_dq hi-Z.
  - Reset mid-access aborts immediately with no response. The first cycle after release is IDLE with req_ready=1.
- FSM states: IDLE, ACC_LO, ACC_HI, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, capture we/addr/wdata/be into registers; req_ready drops next cycle.
  - Next state: ACC_LO. For a write with be[1:0]==0, go to ACC_HI instead. For a write with be==0, go to RESP.
- Address mapping (little-endian):
  - ACC_LO: sram_adr = {addr[ADDR_W:2],1'b0}, bytes 0-1.
  - ACC_HI: sram_adr = {addr[ADDR_W:2],1'b1}, bytes 2-3.
  - addr bits above ADDR_W are ignored.
- Half-word access timing:
  - Each access lasts WAIT_CYCLES+1 cycles, counted by an internal counter.
  - Strobe phase, cycles 0..WAIT_CYCLES-1: ce_n=0; we_n=0 (write) or oe_n=0 (read).
  - Recovery phase, last cycle: ce_n=0, we_n=oe_n=1; address and dq held.
  - Reads: sram_dq is sampled on the clock edge ending the last strobe cycle, into rdata[15:0] (LO) or rdata[31:16] (HI).
  - Writes: dq is driven with the selected half of wdata for the whole access, including recovery. ub_n/lb_n = ~be of that half.
  - Reads: ub_n=lb_n=0.
- ACC_LO -> ACC_HI, except a write with be[3:2]==0, which goes -> RESP. ACC_HI -> RESP.
- RESP: rsp_valid=1 for exactly one cycle; rsp_rdata=assembled word (reads) or 0 (writes). Next state: IDLE.
- dq is driven only in ACC_LO/ACC_HI of a write; hi-Z in every other state and cycle.
- Latency (WAIT_CYCLES=1, full access accepted at cycle T):
  - ACC_LO at T+1..T+2, ACC_HI at T+3..T+4, rsp_valid at T+5, req_ready=1 at T+6.
  - General formula: 2*(WAIT_CYCLES+1)+1 cycles to response.
- req_valid while req_ready=0 is ignored; there is no queueing. Inputs need only be stable in the accept cycle.
- Outside an access, sram_adr holds its last value.

Optional Feature:
- Macro SRAM_BRIDGE_ALIGN_CHECK_EN.
- Defined:
  - Adds output port rsp_err (1 bit, reset 0).
  - A request with req_addr[1:0]!=0 skips both SRAM accesses and goes IDLE->RESP. rsp_valid=1, rsp_err=1, rsp_rdata=0; no SRAM strobe toggles.
  - rsp_err=0 for aligned responses.
- Not defined: no rsp_err port; req_addr[1:0] ignored; every request is treated as word-aligned.

Test Plan:
1. Reset low 3 cycles, then release → all strobes 1, dq hi-Z throughout; req_ready=1 on first cycle after release.
2. Write addr=0x10, data=0xDEADBEEF, be=1111, then read addr=0x10 (SRAM model) →
   - Write: half-address 0x08 receives 0xBEEF, then 0x09 receives 0xDEAD; we_n low 1 cycle each.
   - Read: rsp_rdata=0xDEADBEEF, rsp_valid exactly 5 cycles after accept.
3. Write be=0011 data=0x12345678 addr=0x20 → only half-address 0x10 written with 0x5678, ub_n=lb_n=0; no HI cycle; rsp_valid 3 cycles after accept.
4. Write be=1000 data=0xAB000000 addr=0x20 → only ACC_HI at 0x11 with ub_n=0, lb_n=1; write be=0000 → rsp_valid 1 cycle after accept, no strobes.
5. WAIT_CYCLES=3, read → oe_n low 3 cycles per half, response 9 cycles after accept; assert reset during ACC_HI → strobes high, dq hi-Z that cycle, no rsp_valid.
6. With SRAM_BRIDGE_ALIGN_CHECK_EN, read addr=0x13 → rsp_valid+rsp_err=1, rsp_rdata=0, 1 cycle after accept, ce_n stays 1.
